lcd_pio_sequencer: RTL and testbench
====================================

// Module: lcd_pio_sequencer
// PURPOSE
// - Consumer end of the host->LCD PIO path: turns 32-bit command words written by the PCIe
//   host into HD44780 (16x2 character LCD) bus write cycles with correct setup/enable/hold timing.
// - Runs the LCD power-up init sequence.
// - Holds one command pending while a bus cycle or execution wait is in progress.
// - Sits between the LCD PIO export and the LCD pins; cmd_word is synchronous to clk.
// PARAMETERS
// SETUP_CYC      2       cycles lcd_rs/lcd_data stable before lcd_en rises (>=40 ns)
// EN_CYC         12      cycles lcd_en held high (>=230 ns)
// HOLD_CYC       2       cycles lcd_rs/lcd_data held after lcd_en falls
// EXEC_CYC       2000    wait after a normal command/data write (40 us @ 50 MHz)
// LONG_EXEC_CYC  82000   wait after clear/home, commands 0x01..0x03 with rs=0 (1.64 ms)
// PWRUP_CYC      750000  delay after reset before the first init write (15 ms)
// INIT_EN        1       1: issue init ROM 0x38,0x0C,0x01,0x06 (rs=0) after PWRUP_CYC; 0: go straight to IDLE
// PORTS
// clk         in   1   system clock, the PCIe application clock feeding the PIOs
// rstn        in   1   asynchronous active-low reset
// cmd_word    in   32  [7:0] data, [8] rs, [29] lcd_on, [30] blon, [31] toggle strobe
// lcd_data    out  8   LCD data bus
// lcd_rs      out  1   register select (0 = command, 1 = data)
// lcd_rw      out  1   constant 0 (write only)
// lcd_en      out  1   enable strobe
// lcd_on      out  1   LCD power, registered copy of cmd_word[29]
// lcd_blon    out  1   backlight, registered copy of cmd_word[30]
// busy        out  1   1 while state != IDLE or the pending buffer is valid
// ack_toggle  out  1   flips once per completed host command (init writes do not flip it)
// overflow    out  1   sticky: a command was dropped; cleared only by reset
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0; prev_tog=0; pending empty.
//   State = PWRUP_WAIT if INIT_EN else IDLE. lcd_en drops in the same instant rstn falls.
// - New command: at an edge where cmd_word[31] != prev_tog.
//   - prev_tog updates at that edge.
//   - [8:0] of the word goes to the pending buffer if it is empty, else the word is dropped and overflow is set.
//   - At most one command is accepted per edge.
// - States: PWRUP_WAIT -> INIT -> IDLE; IDLE -> SETUP -> EN_HIGH -> HOLD -> EXEC_WAIT -> IDLE.
//   - INIT walks the 4-entry ROM through the same SETUP..EXEC_WAIT path; init ends after ROM entry 3.
// - In IDLE with a pending or just-accepted command:
//   - Move to SETUP on that edge and free the buffer; a toggle arriving on the same edge may refill it.
//   - lcd_data/lcd_rs are driven from that edge on.
//   - For a command accepted at edge k:
//     - lcd_en rises at k+SETUP_CYC and falls at k+SETUP_CYC+EN_CYC.
//     - data/rs are held to k+S+E+HOLD_CYC.
//     - ack_toggle flips and the state returns to IDLE at k+S+E+H+EXEC.
//     - EXEC = LONG_EXEC_CYC for rs=0 with data 0x01..0x03, else EXEC_CYC.
// - Pending command at the end of EXEC_WAIT: IDLE lasts exactly 1 cycle, then SETUP.
// - Commands arriving during PWRUP_WAIT/INIT are buffered under the same one-deep rules and run after init.
// - lcd_on/lcd_blon follow cmd_word[29]/[30] with 1-cycle latency regardless of state or toggle.
// - Counters size to the largest parameter.
// - Changing cmd_word[7:0]/[8] without a toggle has no effect on the LCD bus.
// TESTING
// Bench parameters: PWRUP_CYC=10, SETUP=2, EN=4, HOLD=2, EXEC=20, LONG=50.
// - Init: INIT_EN=1, release reset.
//   -> 4 lcd_en pulses, rs=0, data 0x38, 0x0C, 0x01, 0x06.
//   -> The gap after 0x01 uses LONG; ack_toggle stays 0; busy drops after the 4th wait.
// - Single write: INIT_EN=0, set cmd_word=0x8000_0141 at edge k.
//   -> lcd_data=0x41, rs=1 from k; en high k+2..k+6; ack_toggle=1 at k+28; busy low at k+28.
// - Clear: toggle with data 0x01, rs=0.
//   -> EXEC_WAIT lasts 50 cycles; a 0x04 command uses 20 cycles.
// - Back-to-back: three toggles within 5 cycles of each other while busy.
//   -> The 2nd runs 1 cycle after the 1st completes; the 3rd is dropped; overflow=1; ack_toggle flips twice.
// - Mid-cycle reset: assert rstn=0 while lcd_en=1.
//   -> lcd_en=0 immediately; after release, no stale write occurs and overflow=0.
// - Side bits: toggle cmd_word[30] alone.
//   -> lcd_blon follows 1 cycle later; no lcd_en pulse occurs.

Source files
------------

// File: rtl/lcd_pio_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_pio_sequencer
// Consumer end of the host->LCD PIO path. Turns 32-bit command words written by
// the host into HD44780 write cycles (setup / enable / hold / execution wait),
// runs the LCD power-up init sequence and buffers one command while busy.
//
// Ports
//   clk         system clock (PCIe application clock feeding the PIOs)
//   rstn        asynchronous active-low reset
//   cmd_word    [7:0] data, [8] rs, [29] lcd_on, [30] blon, [31] toggle strobe
//   lcd_data    LCD data bus
//   lcd_rs      register select (0 = command, 1 = data)
//   lcd_rw      constant 0, write only
//   lcd_en      enable strobe
//   lcd_on      LCD power, registered copy of cmd_word[29]
//   lcd_blon    backlight, registered copy of cmd_word[30]
//   busy        high while not idle or while a command is pending
//   ack_toggle  flips once per completed host command
//   overflow    sticky: a command was dropped; cleared only by reset
// -----------------------------------------------------------------------------
module lcd_pio_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int PWRUP_CYC     = 750000,
  parameter bit INIT_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cmd_word,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy,
  output logic        ack_toggle,
  output logic        overflow
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                max2(LONG_EXEC_CYC, PWRUP_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counters are loaded with (duration - 1) and the state advances when they hit 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_CNT  = INIT_EN ? PWRUP_LD : '0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_EXEC
  } state_t;

  localparam state_t RST_STATE = INIT_EN ? ST_PWRUP : ST_IDLE;

  // Init ROM: 8-bit 2-line 5x8 font, display on / cursor off, clear, entry mode.
  function automatic logic [7:0] rom_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear display and return home need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] data);
    return !rs && (data >= 8'h01) && (data <= 8'h03);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prev_tog;
  logic             pend_vld;
  logic [8:0]       pend_word;
  logic             init_act;
  logic [2:0]       init_idx;

  logic             new_cmd;
  logic             pend_load;
  logic             launch;
  logic [8:0]       launch_word;
  logic             unused_bits;

  assign unused_bits = ^cmd_word[28:9];

  assign new_cmd = cmd_word[31] ^ prev_tog;

  // In IDLE the buffer is emptied by the launch, so a new word is only buffered
  // when the launch came from the buffer; otherwise it launches directly.
  always_comb begin
    pend_load = 1'b0;
    if (new_cmd) begin
      if (state == ST_IDLE) pend_load = pend_vld;
      else                  pend_load = !pend_vld;
    end
  end

  always_comb begin
    launch      = 1'b0;
    launch_word = pend_word;
    case (state)
      ST_IDLE: begin
        if (pend_vld) begin
          launch = 1'b1;
        end else if (new_cmd) begin
          launch      = 1'b1;
          launch_word = cmd_word[8:0];
        end
      end
      ST_INIT: begin
        launch      = 1'b1;
        launch_word = {1'b0, rom_word(init_idx[1:0])};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pend_load) pend_word <= cmd_word[8:0];
  end

  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE) || pend_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RST_STATE;
      cnt        <= RST_CNT;
      prev_tog   <= 1'b0;
      pend_vld   <= 1'b0;
      overflow   <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_on     <= 1'b0;
      lcd_blon   <= 1'b0;
      ack_toggle <= 1'b0;
      init_act   <= 1'b0;
      init_idx   <= 3'd0;
    end else begin
      prev_tog <= cmd_word[31];
      lcd_on   <= cmd_word[29];
      lcd_blon <= cmd_word[30];

      if (new_cmd && (state != ST_IDLE) && pend_vld) overflow <= 1'b1;

      if (state == ST_IDLE) pend_vld <= pend_load;
      else if (pend_load)   pend_vld <= 1'b1;

      case (state)
        ST_PWRUP: begin
          if (cnt == '0) state <= ST_INIT;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INIT, ST_IDLE: begin
          if (launch) begin
            state    <= ST_SETUP;
            cnt      <= SETUP_LD;
            lcd_data <= launch_word[7:0];
            lcd_rs   <= launch_word[8];
            init_act <= (state == ST_INIT);
            if (state == ST_INIT) init_idx <= init_idx + 3'd1;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state  <= ST_EN_HIGH;
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (cnt == '0) begin
            state  <= ST_HOLD;
            lcd_en <= 1'b0;
            cnt    <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_EXEC;
            cnt   <= is_long(lcd_rs, lcd_data) ? LONG_LD : EXEC_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            if (init_act) begin
              // init_idx has already advanced past the entry just written
              state <= (init_idx == 3'd4) ? ST_IDLE : ST_INIT;
            end else begin
              state      <= ST_IDLE;
              ack_toggle <= ~ack_toggle;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pio_sequencer.sv
module tb_lcd_pio_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cmd_word = '0;

  // instance without init sequence
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, ack_toggle, overflow;
  // instance with init sequence
  logic [7:0] i_data;
  logic       i_rs, i_rw, i_en, i_on, i_blon, i_busy, i_ack, i_ovf;

  int   errors = 0;
  int   checks = 0;
  logic tog = 1'b0;
  logic exp_ack = 1'b0;
  logic en_prev = 1'b0;
  int   rises = 0;

  int         rise_c [4];
  logic [7:0] rise_d [4];
  int         rise_n = 0;
  logic       rs_any = 1'b0;
  logic       ack_any = 1'b0;
  int         busy_low = -1;

  always #5 clk = ~clk;

  lcd_pio_sequencer #(
    .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2), .EXEC_CYC(20),
    .LONG_EXEC_CYC(50), .PWRUP_CYC(10), .INIT_EN(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_word(cmd_word),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .busy(busy),
    .ack_toggle(ack_toggle), .overflow(overflow)
  );

  lcd_pio_sequencer #(
    .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2), .EXEC_CYC(20),
    .LONG_EXEC_CYC(50), .PWRUP_CYC(10), .INIT_EN(1'b1)
  ) dut_i (
    .clk(clk), .rstn(rstn), .cmd_word(cmd_word),
    .lcd_data(i_data), .lcd_rs(i_rs), .lcd_rw(i_rw), .lcd_en(i_en),
    .lcd_on(i_on), .lcd_blon(i_blon), .busy(i_busy),
    .ack_toggle(i_ack), .overflow(i_ovf)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock and sample just after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (lcd_en && !en_prev) rises++;
    en_prev = lcd_en;
  endtask

  // flip the strobe with a new 9-bit command; the next edge accepts it
  task automatic send(input logic [8:0] w);
    tog = ~tog;
    cmd_word = {tog, cmd_word[30:29], 20'd0, w};
  endtask

  // run one command, checking the completion edge against the expected length
  task automatic exec_len(input logic [8:0] w, input int total, input string tag);
    send(w);
    for (int i = 0; i <= total; i++) begin
      step();
      if (i == 0) chk8({tag, " data"}, lcd_data, w[7:0]);
      if (i == total - 1) begin
        chk1({tag, " busy before end"}, busy, 1'b1);
        chk1({tag, " ack before end"}, ack_toggle, exp_ack);
      end
      if (i == total) begin
        chk1({tag, " busy at end"}, busy, 1'b0);
        chk1({tag, " ack at end"}, ack_toggle, ~exp_ack);
      end
    end
    exp_ack = ~exp_ack;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_c[i] = 0;
      rise_d[i] = 8'h00;
    end

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst en", lcd_en, 1'b0);
    chk8("rst data", lcd_data, 8'h00);
    chk1("rst rs", lcd_rs, 1'b0);
    chk1("rst rw", lcd_rw, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst ack", ack_toggle, 1'b0);
    chk1("rst ovf", overflow, 1'b0);
    chk1("rst blon", lcd_blon, 1'b0);
    chk1("rst init busy", i_busy, 1'b1);
    chk1("rst init en", i_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // ---------------- init sequence (cycle c = c-th edge after release)
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (i_en && !en_prev) begin
        if (rise_n < 4) begin
          rise_c[rise_n] = c;
          rise_d[rise_n] = i_data;
        end
        rs_any = rs_any | i_rs;
        rise_n++;
      end
      en_prev = i_en;
      ack_any = ack_any | i_ack;
      if (busy_low < 0 && !i_busy) busy_low = c;
    end
    en_prev = lcd_en;
    chki("init pulses", rise_n, 4);
    chk8("init d0", rise_d[0], 8'h38);
    chk8("init d1", rise_d[1], 8'h0C);
    chk8("init d2", rise_d[2], 8'h01);
    chk8("init d3", rise_d[3], 8'h06);
    chki("init first rise", rise_c[0], 13);
    chki("init gap01", rise_c[1] - rise_c[0], 29);
    chki("init gap12", rise_c[2] - rise_c[1], 29);
    chki("init gap23 long", rise_c[3] - rise_c[2], 59);
    chk1("init rs", rs_any, 1'b0);
    chk1("init ack", ack_any, 1'b0);
    chki("init busy drop", busy_low, 156);
    chk1("idle before single", busy, 1'b0);

    // ---------------- single write 0x8000_0141
    send(9'h141);
    chk8("single word", cmd_word[7:0], 8'h41);
    for (int i = 0; i <= 30; i++) begin
      step();
      chk1($sformatf("single en @%0d", i), lcd_en, (i >= 2 && i < 6));
      if (i == 0 || i == 7) begin
        chk8($sformatf("single data @%0d", i), lcd_data, 8'h41);
        chk1($sformatf("single rs @%0d", i), lcd_rs, 1'b1);
      end
      if (i == 27 || i == 28) begin
        chk1($sformatf("single ack @%0d", i), ack_toggle, (i >= 28));
        chk1($sformatf("single busy @%0d", i), busy, (i < 28));
      end
    end
    exp_ack = 1'b1;

    // ---------------- clear (long) vs normal command
    exec_len(9'h001, 58, "clear");
    exec_len(9'h004, 28, "cmd04");

    // ---------------- back-to-back: A at k, B at k+2, C at k+4
    rises = 0;
    send(9'h142);
    for (int i = 0; i <= 90; i++) begin
      step();
      if (i == 1) send(9'h143);
      if (i == 3) send(9'h144);
      if (i == 3) chk1("b2b ovf before", overflow, 1'b0);
      if (i == 4) chk1("b2b ovf set", overflow, 1'b1);
      if (i == 28) begin
        chk8("b2b A data", lcd_data, 8'h42);
        chk1("b2b A ack", ack_toggle, ~exp_ack);
        chk1("b2b busy pend", busy, 1'b1);
      end
      if (i == 29) begin
        chk8("b2b B data", lcd_data, 8'h43);
        chk1("b2b B rs", lcd_rs, 1'b1);
        chk1("b2b B en low", lcd_en, 1'b0);
      end
      if (i == 31) chk1("b2b B en high", lcd_en, 1'b1);
      if (i == 56) chk1("b2b busy B", busy, 1'b1);
      if (i == 57) begin
        chk1("b2b idle", busy, 1'b0);
        chk1("b2b ack twice", ack_toggle, exp_ack);
      end
    end
    chki("b2b pulses", rises, 2);
    chk1("b2b ovf sticky", overflow, 1'b1);

    // ---------------- reset while lcd_en is high
    send(9'h150);
    step();
    step();
    step();
    chk1("mid en high", lcd_en, 1'b1);
    #2;
    rstn = 1'b0;
    cmd_word = '0;
    tog = 1'b0;
    #1;
    chk1("mid en dropped", lcd_en, 1'b0);
    chk1("mid ovf cleared", overflow, 1'b0);
    chk8("mid data cleared", lcd_data, 8'h00);
    chk1("mid ack cleared", ack_toggle, 1'b0);
    exp_ack = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    en_prev = lcd_en;
    rises = 0;
    for (int i = 0; i < 40; i++) step();
    chki("mid no stale write", rises, 0);
    chk1("mid busy", busy, 1'b0);
    chk1("mid ack", ack_toggle, 1'b0);
    chk1("mid ovf", overflow, 1'b0);

    // ---------------- side bits and data changes without a toggle
    chk1("side blon before", lcd_blon, 1'b0);
    cmd_word[30] = 1'b1;
    cmd_word[8:0] = 9'h1FF;
    chk1("side blon not yet", lcd_blon, 1'b0);
    step();
    chk1("side blon", lcd_blon, 1'b1);
    chk1("side on still 0", lcd_on, 1'b0);
    cmd_word[29] = 1'b1;
    step();
    chk1("side on", lcd_on, 1'b1);
    rises = 0;
    for (int i = 0; i < 30; i++) step();
    chki("side no pulse", rises, 0);
    chk8("side data", lcd_data, 8'h00);
    chk1("side busy", busy, 1'b0);
    chk1("side ack", ack_toggle, 1'b0);
    cmd_word[30] = 1'b0;
    step();
    chk1("side blon off", lcd_blon, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
